// File: rtl/axi_llc_cfg_seq.sv
// RegBus master that programs the LLC SPM and flush way masks, commits them,
// then polls the flush register until the requested ways have finished flushing.
module axi_llc_cfg_seq #(
    parameter int unsigned SetAssociativity = 8,
    parameter logic [31:0] BaseAddr         = 32'h0,
    parameter logic [31:0] SpmOffset        = 32'h00,
    parameter logic [31:0] FlushOffset      = 32'h08,
    parameter logic [31:0] CommitOffset     = 32'h10,
    parameter int unsigned PollInterval     = 16,
    parameter int unsigned MaxPolls         = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [SetAssociativity-1:0] spm_mask_i,
    input  logic [SetAssociativity-1:0] flush_mask_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic                        timeout_o,
    output logic [31:0]                 conf_req_addr,
    output logic                        conf_req_w,
    output logic [31:0]                 conf_req_wdata,
    output logic [3:0]                  conf_req_wstrb,
    output logic                        conf_req_valid,
    input  logic [31:0]                 conf_resp_rdata,
    input  logic                        conf_resp_error,
    input  logic                        conf_resp_ready
);

    localparam int unsigned PollW = $clog2(MaxPolls + 1);
    localparam int unsigned WaitW = $clog2(PollInterval + 1);
    localparam logic [PollW-1:0] MaxPollsC = PollW'(MaxPolls);
    localparam logic [WaitW-1:0] WaitLast  = WaitW'(PollInterval - 1);
    localparam logic [31:0] SpmAddr    = BaseAddr + SpmOffset;
    localparam logic [31:0] FlushAddr  = BaseAddr + FlushOffset;
    localparam logic [31:0] CommitAddr = BaseAddr + CommitOffset;

    typedef enum logic [2:0] {
        IDLE, WR_SPM, WR_FLUSH, WR_COMMIT, POLL_RD, POLL_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               timeout_q, timeout_d;
    logic               valid_q, valid_d;
    logic               w_q, w_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        flush_mask_q, flush_mask_d;
    logic [PollW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               xfer;

    // A transfer completes in the cycle ready is seen with our request valid.
    assign xfer = valid_q && conf_resp_ready;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        timeout_d    = 1'b0;
        valid_d      = valid_q;
        w_d          = w_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        flush_mask_d = flush_mask_q;
        poll_cnt_d   = poll_cnt_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            IDLE: begin
                // The done/error cycle still counts as busy for start purposes.
                if (start_i && !done_q && !error_q) begin
                    state_d      = WR_SPM;
                    busy_d       = 1'b1;
                    valid_d      = 1'b1;
                    w_d          = 1'b1;
                    addr_d       = SpmAddr;
                    wdata_d      = 32'(spm_mask_i);
                    flush_mask_d = 32'(flush_mask_i);
                    poll_cnt_d   = '0;
                    wait_cnt_d   = '0;
                end
            end
            WR_SPM: begin
                if (xfer) begin
                    state_d = WR_FLUSH;
                    addr_d  = FlushAddr;
                    wdata_d = flush_mask_q;
                end
            end
            WR_FLUSH: begin
                if (xfer) begin
                    state_d = WR_COMMIT;
                    addr_d  = CommitAddr;
                    wdata_d = 32'h1;
                end
            end
            WR_COMMIT: begin
                if (xfer) begin
                    if (flush_mask_q == 32'h0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        w_d     = 1'b0;
                    end else begin
                        state_d    = POLL_RD;
                        w_d        = 1'b0;
                        addr_d     = FlushAddr;
                        wdata_d    = 32'h0;
                        poll_cnt_d = '0;
                    end
                end
            end
            POLL_RD: begin
                if (xfer) begin
                    poll_cnt_d = poll_cnt_q + PollW'(1);
                    if ((conf_resp_rdata & flush_mask_q) == 32'h0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else if (poll_cnt_d == MaxPollsC) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        error_d   = 1'b1;
                        timeout_d = 1'b1;
                        valid_d   = 1'b0;
                    end else begin
                        state_d    = POLL_WAIT;
                        valid_d    = 1'b0;
                        wait_cnt_d = '0;
                    end
                end
            end
            POLL_WAIT: begin
                if (wait_cnt_q == WaitLast) begin
                    state_d = POLL_RD;
                    valid_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A bus error on any completion overrides whatever the state decided.
        if (xfer && conf_resp_error) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
            timeout_d = 1'b0;
            valid_d   = 1'b0;
            w_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            valid_q      <= 1'b0;
            w_q          <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            flush_mask_q <= 32'h0;
            poll_cnt_q   <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
            valid_q      <= valid_d;
            w_q          <= w_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            flush_mask_q <= flush_mask_d;
            poll_cnt_q   <= poll_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign timeout_o      = timeout_q;
    assign conf_req_valid = valid_q;
    assign conf_req_w     = w_q;
    assign conf_req_addr  = addr_q;
    assign conf_req_wdata = wdata_q;
    assign conf_req_wstrb = 4'hF;

endmodule
